// File: rtl/autonomous_digital_system_pkg.sv
// Shared constants for the autonomous accumulator machine: sizes, opcodes, default program.
package autonomous_digital_system_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int PROG_DEPTH_DEF = 16;
  localparam int PC_W           = 4;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_LOAD   = 4'h1,
    OP_ADD    = 4'h2,
    OP_SUB    = 4'h3,
    OP_AND    = 4'h4,
    OP_OR     = 4'h5,
    OP_XOR    = 4'h6,
    OP_NOT    = 4'h7,
    OP_SHL    = 4'h8,
    OP_SHR    = 4'h9,
    OP_LOADHI = 4'hA,
    OP_JMP    = 4'hB,
    OP_JZ     = 4'hC,
    OP_JNZ    = 4'hD,
    OP_RSVD   = 4'hE,
    OP_HALT   = 4'hF
  } opcode_t;

  // Concatenation lists address 15 first, so element [0] is the reset-vector word.
  localparam logic [PROG_DEPTH_DEF-1:0][DATA_W_DEF-1:0] DEFAULT_ROM = {
    8'h00, 8'hF0, 8'h2F, 8'h47, 8'h90, 8'h70, 8'h53, 8'hAA,
    8'h1F, 8'hC8, 8'h31, 8'h6F, 8'h80, 8'h31, 8'h23, 8'h15
  };

endpackage

// File: rtl/autonomous_digital_system_if.sv
// Instruction fetch bus between the core (master drives address) and the program ROM.
interface autonomous_digital_system_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  modport master (output addr, input  data);
  modport slave  (input  addr, output data);
endinterface

// File: rtl/autonomous_digital_system_rom.sv
// Combinational program ROM; contents fixed by the ROM_IMAGE parameter.
module program_rom
  import autonomous_digital_system_pkg::*;
#(
  parameter int PROG_DEPTH = PROG_DEPTH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter logic [PROG_DEPTH-1:0][DATA_W-1:0] ROM_IMAGE = DEFAULT_ROM
) (
  autonomous_digital_system_if.slave bus
);

  assign bus.data = ROM_IMAGE[bus.addr];

endmodule

// File: rtl/autonomous_digital_system.sv
// Single-cycle accumulator machine: fetch, decode and execute complete on every clock edge.
module autonomous_digital_system
  import autonomous_digital_system_pkg::*;
#(
  parameter int PROG_DEPTH = PROG_DEPTH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter logic [PROG_DEPTH-1:0][DATA_W-1:0] ROM_IMAGE = DEFAULT_ROM
) (
  input  logic              clock,
  input  logic              reset,
  output logic [DATA_W-1:0] accumulator
);

  // Probe-visible names are kept exactly as benches expect them.
  logic [PC_W-1:0]   ProgramCounter;
  logic [DATA_W-1:0] instructionFromMemory;
  logic [3:0]        Command;
  logic [3:0]        Value;

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [PC_W-1:0]   w_pc_inc;
  logic [DATA_W-1:0] w_val_ext;

  autonomous_digital_system_if #(.AW(PC_W), .DW(DATA_W)) u_bus ();

  program_rom #(
    .PROG_DEPTH (PROG_DEPTH),
    .DATA_W     (DATA_W),
    .ROM_IMAGE  (ROM_IMAGE)
  ) u_rom (
    .bus (u_bus.slave)
  );

  assign u_bus.addr            = ProgramCounter;
  assign instructionFromMemory = u_bus.data;
  assign Command               = instructionFromMemory[7:4];
  assign Value                 = instructionFromMemory[3:0];
  assign w_val_ext             = {4'h0, Value};
  assign w_pc_inc              = ProgramCounter + 4'd1;
  assign accumulator           = r_acc;

  // Decode/execute: next accumulator and next PC from the current instruction and pre-edge acc.
  always_comb begin
    w_acc_nxt = r_acc;
    w_pc_nxt  = w_pc_inc;
    case (opcode_t'(Command))
      OP_LOAD:   w_acc_nxt = w_val_ext;
      OP_ADD:    w_acc_nxt = r_acc + w_val_ext;
      OP_SUB:    w_acc_nxt = r_acc - w_val_ext;
      OP_AND:    w_acc_nxt = r_acc & w_val_ext;
      OP_OR:     w_acc_nxt = r_acc | w_val_ext;
      OP_XOR:    w_acc_nxt = r_acc ^ w_val_ext;
      OP_NOT:    w_acc_nxt = ~r_acc;
      OP_SHL:    w_acc_nxt = {r_acc[6:0], 1'b0};
      OP_SHR:    w_acc_nxt = {1'b0, r_acc[7:1]};
      OP_LOADHI: w_acc_nxt = {Value, r_acc[3:0]};
      OP_JMP:    w_pc_nxt  = Value;
      OP_JZ:     if (r_acc == '0) w_pc_nxt = Value;
      OP_JNZ:    if (r_acc != '0) w_pc_nxt = Value;
      OP_HALT:   w_pc_nxt  = ProgramCounter;
      default:   ;
    endcase
  end

  // Architectural state; reset wins over whatever instruction is being fetched.
  always_ff @(posedge clock) begin
    if (reset) begin
      ProgramCounter <= '0;
      r_acc          <= '0;
    end else begin
      ProgramCounter <= w_pc_nxt;
      r_acc          <= w_acc_nxt;
    end
  end

endmodule

// File: tb/tb_autonomous_digital_system.sv
// Bench: two machines (default program, all-ADD-F program) against a behavioural ISA model.
module tb_autonomous_digital_system;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [7:0] acc_a, acc_b;

  localparam logic [15:0][7:0] ROM_ALL_ADDF = {16{8'h2F}};

  autonomous_digital_system u_a (
    .clock       (clk),
    .reset       (rst_a),
    .accumulator (acc_a)
  );

  autonomous_digital_system #(.ROM_IMAGE(ROM_ALL_ADDF)) u_b (
    .clock       (clk),
    .reset       (rst_b),
    .accumulator (acc_b)
  );

  // Program images as the bench understands them, index = address.
  logic [7:0] rom_a [16] = '{8'h15, 8'h23, 8'h31, 8'h80, 8'h6F, 8'h31, 8'hC8, 8'h1F,
                             8'hAA, 8'h53, 8'h70, 8'h90, 8'h47, 8'h2F, 8'hF0, 8'h00};
  logic [7:0] rom_b [16] = '{default: 8'h2F};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ISA rules in plain arithmetic on integers.
  function automatic int next_acc(input logic [7:0] ins, input int acc);
    int op, v;
    op = int'(ins) / 16;
    v  = int'(ins) % 16;
    case (op)
      1:       return v;
      2:       return (acc + v) % 256;
      3:       return (acc - v + 256) % 256;
      4:       return acc & v;
      5:       return acc | v;
      6:       return acc ^ v;
      7:       return 255 - acc;
      8:       return (acc * 2) % 256;
      9:       return acc / 2;
      10:      return v * 16 + acc % 16;
      default: return acc;
    endcase
  endfunction

  function automatic int next_pc(input logic [7:0] ins, input int pc, input int acc);
    int op, v;
    op = int'(ins) / 16;
    v  = int'(ins) % 16;
    case (op)
      11:      return v;
      12:      return (acc == 0) ? v : (pc + 1) % 16;
      13:      return (acc != 0) ? v : (pc + 1) % 16;
      15:      return pc;
      default: return (pc + 1) % 16;
    endcase
  endfunction

  int   ma_pc = 0, ma_acc = 0, mb_pc = 0, mb_acc = 0;
  logic started = 1'b0;

  // Reference model advances on the same edge as the DUTs.
  always @(posedge clk) begin
    if (rst_a) begin
      ma_pc  <= 0;
      ma_acc <= 0;
    end else begin
      ma_pc  <= next_pc(rom_a[ma_pc], ma_pc, ma_acc);
      ma_acc <= next_acc(rom_a[ma_pc], ma_acc);
    end
    if (rst_b) begin
      mb_pc  <= 0;
      mb_acc <= 0;
    end else begin
      mb_pc  <= next_pc(rom_b[mb_pc], mb_pc, mb_acc);
      mb_acc <= next_acc(rom_b[mb_pc], mb_acc);
    end
    started <= 1'b1;
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("a_acc",   acc_a, ma_acc);
      chk("a_pc",    u_a.ProgramCounter, ma_pc);
      chk("a_instr", u_a.instructionFromMemory, rom_a[ma_pc]);
      chk("a_cmd",   u_a.Command, rom_a[ma_pc] >> 4);
      chk("a_val",   u_a.Value, rom_a[ma_pc] & 8'h0F);
      chk("b_acc",   acc_b, mb_acc);
      chk("b_pc",    u_b.ProgramCounter, mb_pc);
      chk("b_instr", u_b.instructionFromMemory, rom_b[mb_pc]);
      chk("b_cmd",   u_b.Command, u_b.instructionFromMemory[7:4]);
      chk("b_val",   u_b.Value, u_b.instructionFromMemory[3:0]);
    end
  end

  // Directed sequence with hand-computed literals, then randomized reset traffic.
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_acc", acc_a, 0);
    chk("rst_pc",  u_a.ProgramCounter, 0);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("e3_acc", acc_a, 7);
    chk("e3_pc",  u_a.ProgramCounter, 3);
    repeat (3) @(negedge clk);
    chk("e6_acc", acc_a, 0);
    @(negedge clk);
    chk("e7_pc",  u_a.ProgramCounter, 8);
    chk("e7_acc", acc_a, 0);
    repeat (6) @(negedge clk);
    chk("e13_acc", acc_a, 21);
    chk("e13_pc",  u_a.ProgramCounter, 14);
    repeat (10) @(negedge clk);
    chk("halt_acc", acc_a, 21);
    chk("halt_pc",  u_a.ProgramCounter, 14);

    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (9) @(negedge clk);
    chk("e9_acc", acc_a, 8'hA3);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_acc", acc_a, 0);
    chk("mid_rst_pc",  u_a.ProgramCounter, 0);
    rst_a = 1'b0;
    @(negedge clk);
    chk("restart_acc", acc_a, 5);

    rst_b = 1'b0;
    repeat (16) @(negedge clk);
    chk("addf16_acc", acc_b, 240);
    chk("addf16_pc",  u_b.ProgramCounter, 0);
    @(negedge clk);
    chk("addf17_acc", acc_b, 255);
    @(negedge clk);
    chk("addf18_acc", acc_b, 14);
    chk("addf18_pc",  u_b.ProgramCounter, 2);

    repeat (600) begin
      rst_a = ($urandom_range(0, 15) == 0);
      rst_b = ($urandom_range(0, 23) == 0);
      @(negedge clk);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/autonomous_digital_system.md
AUTONOMOUS_DIGITAL_SYSTEM -- requirements
Module: autonomous_digital_system

Interface
REQ-001 Parameter PROG_DEPTH, default 16: number of program ROM words, addressed by a 4-bit program counter.
REQ-002 Parameter DATA_W, default 8: width of the accumulator and of each instruction word.
REQ-003 Port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port accumulator, output, 8 bits: current accumulator register value, driven directly from the register.
REQ-006 Internal nets ProgramCounter [3:0], instructionFromMemory [7:0], Command [3:0] and Value [3:0] SHALL exist under exactly these names, for hierarchical probing by benches.

Function
REQ-007 instructionFromMemory SHALL be a combinational ROM read at ProgramCounter; Command = instruction[7:4], Value = instruction[3:0].
REQ-008 The block SHALL execute one instruction per clock (fetch, decode and execute in the same cycle); accumulator and ProgramCounter update on the same rising edge.
REQ-009 Opcodes, with acc = accumulator and V = Value:
- 0 NOP: no change.
- 1 LOAD: acc = {4'h0, V}.
- 2 ADD: acc = acc + V.
- 3 SUB: acc = acc - V.
- 4 AND / 5 OR / 6 XOR: acc op {4'h0, V}.
- 7 NOT: acc = ~acc.
- 8 SHL: acc << 1, zero fill.
- 9 SHR: acc >> 1, zero fill.
- A LOADHI: acc[7:4] = V, low nibble kept.
- B JMP: PC = V.
- C JZ: PC = V if acc == 0, else PC + 1.
- D JNZ: PC = V if acc != 0, else PC + 1.
- E: reserved, behaves as NOP.
- F HALT: PC and acc hold until reset.
REQ-010 All arithmetic SHALL be modulo 256 (carry and borrow discarded); no flags are exported.
REQ-011 Jump conditions SHALL use the accumulator value before the current edge.
REQ-012 For all non-jump, non-HALT opcodes, PC SHALL advance to PC + 1, wrapping from 15 to 0.
REQ-013 The ROM default program SHALL be, by address (hex):
- 0: 15, 1: 23, 2: 31, 3: 80, 4: 6F, 5: 31, 6: C8, 7: 1F
- 8: AA, 9: 53, 10: 70, 11: 90, 12: 47, 13: 2F, 14: F0, 15: 00
REQ-014 Expected accumulator after each post-reset edge: 5, 8, 7, 14, 1, 0, 0 (JZ taken to address 8, address 7 skipped), A0h, A3h, 5Ch, 2Eh, 06h, 15h (21); HALT then holds 21 with PC = 14 indefinitely.

Reset
REQ-015 While reset is high at a rising edge, ProgramCounter SHALL become 0 and accumulator SHALL become 0, with no instruction executed on that edge.
REQ-016 Reset asserted mid-program or during HALT SHALL restart execution from address 0 on the first edge after deassertion; reset takes priority over every opcode.

Structure
REQ-017 A shared package SHALL hold the opcode constants, the DATA_W and PROG_DEPTH defaults, and the default ROM image.
REQ-018 One sub-module, program_rom, SHALL implement the combinational 16x8 ROM; decode and execute SHALL reside in autonomous_digital_system.

Verification
REQ-019 Reset high for one edge, then 3 edges -> accumulator = 7 (decimal), ProgramCounter = 3.
REQ-020 Run 6 edges -> accumulator = 0; 7th edge -> ProgramCounter = 8 (JZ taken), accumulator stays 0.
REQ-021 Run 13 edges -> accumulator = 21 (15h); a further 10 edges -> accumulator stays 21 and ProgramCounter stays 14.
REQ-022 Reset asserted for one edge after edge 9 (accumulator = A3h) -> accumulator = 0, PC = 0; next edge -> accumulator = 5.
REQ-023 ROM override with ADD F at all 16 addresses -> accumulator sequence 15, 30, ..., 255, then wraps to 14; PC wraps from 15 to 0.
REQ-024 Every cycle, check Command and Value against instructionFromMemory[7:4] and [3:0].
